route_compute_fsm: RTL
======================

Name: route_compute_fsm

Overview:
- Registered, per-buffer route computation stage for the chiplet switch. Successor to the purely combinational route-compute interface.
- Looks up each head flit's destination in a range-match routing table, then holds a locked outport request toward the switch allocator for the whole wormhole packet.
- Adds the following over the combinational version:
  - local-delivery bypass;
  - no-match and illegal-port drop handling;
  - per-buffer packet state;
  - a saturating error counter.
- Sits between the input buffers and the switch allocator.

Parameters:
- NUM_BUFFERS, 5, number of input buffers (one FSM each)
- NUM_OUTPORTS, 5, number of switch outports
- TABLE_SIZE, 32, routing LUT entries
- NODE_ID_W, 8, destination node-id width
- LOCAL_PORT, 0, outport used when dest equals node_id
- ERR_CNT_W, 16, error counter width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- node_id  in  NODE_ID_W  this switch's node id
- route_lut  in  TABLE_SIZE x route_lut_t  routing table {en, lo, hi, port}
- in_valid  in  NUM_BUFFERS  buffer head slot holds a flit
- in_head  in  NUM_BUFFERS  that flit is a packet head
- in_dest  in  NUM_BUFFERS x NODE_ID_W  dest id of head flit (meaningful when in_head)
- grant  in  NUM_BUFFERS  switch allocator granted buffer's request
- tail_done  in  NUM_BUFFERS  pulse: tail flit of buffer's packet left the buffer
- allocate  out  NUM_BUFFERS  outport request valid
- out_sel  out  NUM_BUFFERS x SELECT_SIZE  requested outport
- drop  out  NUM_BUFFERS  buffer must discard flits until tail_done
- route_err  out  1  one-cycle pulse, any buffer entered DROP this cycle
- err_count  out  ERR_CNT_W  saturating count of dropped packets

Behaviour:
- Reset (async, rst=1):
  - every FSM goes to IDLE;
  - allocate=0, out_sel=0, drop=0, route_err=0, err_count=0.
- Per-buffer FSM states: IDLE, LOOKUP, REQ, ACTIVE, DROP.
- IDLE:
  - in_valid & in_head -> latch in_dest and go to LOOKUP.
  - Non-head flits in IDLE are ignored. That is a protocol violation; assert in simulation only.
- LOOKUP (exactly 1 cycle; lookup is computed from the latched dest):
  - dest == node_id -> port = LOCAL_PORT; this has priority over the LUT.
  - Otherwise the lowest-index entry with en & lo <= dest <= hi wins.
  - A match whose port >= NUM_OUTPORTS is treated as no-match.
  - Valid result -> REQ, with out_sel registered.
  - No match -> DROP.
- REQ:
  - allocate=1, out_sel stable.
  - grant -> ACTIVE.
  - grant & tail_done in the same cycle (single-flit packet) -> IDLE.
  - tail_done without grant is illegal; ignore it.
- ACTIVE:
  - allocate=1, out_sel locked. The route does not change even if route_lut changes.
  - tail_done -> IDLE.
- DROP:
  - drop=1, allocate=0.
  - tail_done -> IDLE.
- route_err / err_count:
  - route_err=1 in the cycle a LOOKUP->DROP transition is registered.
  - err_count increments by the number of buffers entering DROP in that cycle, saturating at all-ones.
- Latency:
  - head visible in IDLE -> allocate high 2 cycles later (IDLE->LOOKUP->REQ).
  - allocate deasserts the cycle after tail_done.
- grant is ignored in IDLE, LOOKUP and DROP.
- Buffers are fully independent. Several may request the same outport; arbitration belongs to the allocator.
- route_lut is sampled only in LOOKUP. Table writes mid-packet take effect on the next head.
- Reset mid-packet: all state cleared; upstream buffers are flushed by the same reset.
- SELECT_SIZE = $clog2(NUM_OUTPORTS) + (NUM_OUTPORTS == 1).
- Range compare is unsigned. lo > hi means the entry never matches.

Decomposition:
- switch_pkg holds:
  - route_lut_t {logic en; logic [NODE_ID_W-1:0] lo, hi; logic [SELECT_SIZE-1:0] port};
  - the rc_state_e enum;
  - a SELECT_SIZE helper function.
- One sub-module, route_lut_lookup: combinational priority range-match plus local bypass, returning {hit, port}.
- Instantiate route_lut_lookup once per buffer, fed from that buffer's latched dest.
- route_compute_if gains clk, rst, node_id, in_valid, in_head, in_dest, grant, tail_done, drop, route_err and err_count, in a new modport.

Test Plan:
1. node_id=3, buffer 1 head dest=3 -> allocate[1]=1 with out_sel[1]=LOCAL_PORT(0) two cycles later; route_err stays 0.
2. LUT entry0 {en=1, lo=10, hi=19, port=2}, entry1 {en=1, lo=15, hi=30, port=4}; head dest=16 -> out_sel=2 (lowest index wins); dest=25 -> out_sel=4.
3. Head dest=50 with no matching entry -> drop=1, route_err pulse, err_count=1. tail_done 4 cycles later -> IDLE, drop=0. A second such packet -> err_count=2.
4. Single-flit packet, grant & tail_done in the same cycle in REQ -> allocate=0 the next cycle, FSM IDLE; a back-to-back head is accepted immediately.
5. Buffers 0 and 2 both route to port 3, grant to 0 only -> allocate[2] stays 1 until granted. Changing the LUT while buffer 0 is ACTIVE leaves out_sel[0]=3.
6. Assert rst while in ACTIVE and DROP -> all outputs 0 immediately (asynchronous). Preload err_count to all-ones via repeated drops -> it saturates and does not wrap.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types, sizes and helpers for the switch route-compute stage
package switch_pkg;

    localparam int SW_NODE_ID_W    = 8;
    localparam int SW_NUM_OUTPORTS = 5;

    // Outport select width; a single-outport switch still needs one bit.
    function automatic int select_size(input int n);
        return $clog2(n) + ((n == 1) ? 1 : 0);
    endfunction

    localparam int SELECT_SIZE = select_size(SW_NUM_OUTPORTS);

    // One routing-table entry: matches lo <= dest <= hi (unsigned) when en.
    typedef struct packed {
        logic                    en;
        logic [SW_NODE_ID_W-1:0] lo;
        logic [SW_NODE_ID_W-1:0] hi;
        logic [SELECT_SIZE-1:0]  port;
    } route_lut_t;

    typedef enum logic [2:0] {
        RC_IDLE,
        RC_LOOKUP,
        RC_REQ,
        RC_ACTIVE,
        RC_DROP
    } rc_state_e;

endpackage

// File: rtl/route_lut_lookup.sv
// rtl/route_lut_lookup.sv - combinational priority range-match with local-delivery bypass
//
// Ports:
//   dest_i     destination node id to route
//   node_id_i  this switch's node id (local bypass compare)
//   lut_i      routing table, lowest index has priority
//   hit_o      a legal outport was found
//   port_o     selected outport (0 when no hit)
module route_lut_lookup
    import switch_pkg::*;
#(
    parameter int TABLE_SIZE   = 32,
    parameter int NUM_OUTPORTS = SW_NUM_OUTPORTS,
    parameter int NODE_ID_W    = SW_NODE_ID_W,
    parameter int LOCAL_PORT   = 0
) (
    input  logic [NODE_ID_W-1:0]   dest_i,
    input  logic [NODE_ID_W-1:0]   node_id_i,
    input  route_lut_t             lut_i [TABLE_SIZE],
    output logic                   hit_o,
    output logic [SELECT_SIZE-1:0] port_o
);

    localparam logic [SELECT_SIZE:0]   NUM_OUT_L = (SELECT_SIZE + 1)'(NUM_OUTPORTS);
    localparam logic [SELECT_SIZE-1:0] LOCAL_SEL = SELECT_SIZE'(LOCAL_PORT);

    logic found;

    always_comb begin
        hit_o  = 1'b0;
        port_o = '0;
        found  = 1'b0;
        if (dest_i == node_id_i) begin
            hit_o  = 1'b1;
            port_o = LOCAL_SEL;
        end else begin
            for (int i = 0; i < TABLE_SIZE; i++) begin
                // Only the first matching entry decides; an out-of-range port
                // on that entry makes the whole lookup a miss.
                if (!found && lut_i[i].en &&
                    (lut_i[i].lo <= dest_i) && (dest_i <= lut_i[i].hi)) begin
                    found = 1'b1;
                    if ({1'b0, lut_i[i].port} < NUM_OUT_L) begin
                        hit_o  = 1'b1;
                        port_o = lut_i[i].port;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/route_compute_fsm.sv
// rtl/route_compute_fsm.sv - per-buffer registered route compute with locked outport requests
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   node_id      this switch's node id
//   route_lut    routing table {en, lo, hi, port}
//   in_valid     buffer head slot holds a flit
//   in_head      that flit is a packet head
//   in_dest      per-buffer destination of the head flit
//   grant        allocator granted the buffer's request
//   tail_done    tail flit of the buffer's packet has left
//   allocate     outport request valid
//   out_sel      requested outport, locked for the packet
//   drop         buffer discards flits until tail_done
//   route_err    pulse: at least one buffer entered DROP
//   err_count    saturating dropped-packet count
module route_compute_fsm
    import switch_pkg::*;
#(
    parameter int NUM_BUFFERS  = 5,
    parameter int NUM_OUTPORTS = SW_NUM_OUTPORTS,
    parameter int TABLE_SIZE   = 32,
    parameter int NODE_ID_W    = SW_NODE_ID_W,
    parameter int LOCAL_PORT   = 0,
    parameter int ERR_CNT_W    = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NODE_ID_W-1:0]                    node_id,
    input  route_lut_t                              route_lut [TABLE_SIZE],
    input  logic [NUM_BUFFERS-1:0]                  in_valid,
    input  logic [NUM_BUFFERS-1:0]                  in_head,
    input  logic [NUM_BUFFERS-1:0][NODE_ID_W-1:0]   in_dest,
    input  logic [NUM_BUFFERS-1:0]                  grant,
    input  logic [NUM_BUFFERS-1:0]                  tail_done,
    output logic [NUM_BUFFERS-1:0]                  allocate,
    output logic [NUM_BUFFERS-1:0][SELECT_SIZE-1:0] out_sel,
    output logic [NUM_BUFFERS-1:0]                  drop,
    output logic                                    route_err,
    output logic [ERR_CNT_W-1:0]                    err_count
);

    localparam int CNT_W = $clog2(NUM_BUFFERS + 1);

    rc_state_e              state_q [NUM_BUFFERS];
    rc_state_e              state_d [NUM_BUFFERS];
    logic [NODE_ID_W-1:0]   dest_q  [NUM_BUFFERS];
    logic [NODE_ID_W-1:0]   dest_d  [NUM_BUFFERS];
    logic [SELECT_SIZE-1:0] sel_q   [NUM_BUFFERS];
    logic [SELECT_SIZE-1:0] sel_d   [NUM_BUFFERS];
    logic                   route_err_q, route_err_d;
    logic [ERR_CNT_W-1:0]   err_q, err_d;

    logic [NUM_BUFFERS-1:0]                  lk_hit;
    logic [NUM_BUFFERS-1:0][SELECT_SIZE-1:0] lk_port;
    logic [NUM_BUFFERS-1:0]                  enter_drop;
    logic [NUM_BUFFERS-1:0]                  idle_nonhead;
    logic [CNT_W-1:0]                        drop_cnt;
    logic [ERR_CNT_W:0]                      err_sum;

    // Each lookup sees only its own latched dest, so the table is consulted
    // exactly in the LOOKUP cycle and never again for that packet.
    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_lookup
        route_lut_lookup #(
            .TABLE_SIZE   (TABLE_SIZE),
            .NUM_OUTPORTS (NUM_OUTPORTS),
            .NODE_ID_W    (NODE_ID_W),
            .LOCAL_PORT   (LOCAL_PORT)
        ) u_lookup (
            .dest_i    (dest_q[g]),
            .node_id_i (node_id),
            .lut_i     (route_lut),
            .hit_o     (lk_hit[g]),
            .port_o    (lk_port[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                state_q[b] <= RC_IDLE;
                dest_q[b]  <= '0;
                sel_q[b]   <= '0;
            end
            route_err_q <= 1'b0;
            err_q       <= '0;
        end else begin
            for (int b = 0; b < NUM_BUFFERS; b++) begin
                state_q[b] <= state_d[b];
                dest_q[b]  <= dest_d[b];
                sel_q[b]   <= sel_d[b];
            end
            route_err_q <= route_err_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        enter_drop   = '0;
        idle_nonhead = '0;
        drop_cnt     = '0;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            state_d[b] = state_q[b];
            dest_d[b]  = dest_q[b];
            sel_d[b]   = sel_q[b];
            unique case (state_q[b])
                RC_IDLE: begin
                    idle_nonhead[b] = in_valid[b] & ~in_head[b];
                    if (in_valid[b] && in_head[b]) begin
                        dest_d[b]  = in_dest[b];
                        state_d[b] = RC_LOOKUP;
                    end
                end
                RC_LOOKUP: begin
                    if (lk_hit[b]) begin
                        sel_d[b]   = lk_port[b];
                        state_d[b] = RC_REQ;
                    end else begin
                        enter_drop[b] = 1'b1;
                        state_d[b]    = RC_DROP;
                    end
                end
                RC_REQ: begin
                    // A lone tail_done here has no granted packet to end.
                    if (grant[b]) begin
                        state_d[b] = tail_done[b] ? RC_IDLE : RC_ACTIVE;
                    end
                end
                RC_ACTIVE: begin
                    if (tail_done[b]) state_d[b] = RC_IDLE;
                end
                RC_DROP: begin
                    if (tail_done[b]) state_d[b] = RC_IDLE;
                end
                default: state_d[b] = RC_IDLE;
            endcase
            drop_cnt = drop_cnt + CNT_W'(enter_drop[b]);
        end
        route_err_d = |enter_drop;
        err_sum     = {1'b0, err_q} + (ERR_CNT_W + 1)'(drop_cnt);
        err_d       = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    always_comb begin
        allocate = '0;
        drop     = '0;
        out_sel  = '0;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            allocate[b] = (state_q[b] == RC_REQ) || (state_q[b] == RC_ACTIVE);
            drop[b]     = (state_q[b] == RC_DROP);
            out_sel[b]  = sel_q[b];
        end
    end

    assign route_err = route_err_q;
    assign err_count = err_q;

    // Body flits arriving at an idle buffer mean upstream lost packet framing.
    a_no_idle_body: assert property (@(posedge clk) disable iff (rst) idle_nonhead == '0);

endmodule
